// File: rtl/dram_cmd_scheduler_if.sv
// rtl/dram_cmd_scheduler_if.sv - request and DDR4 command bus bundle for dram_cmd_scheduler
interface dram_cmd_scheduler_if #(
  parameter int ADDR_WIDTH          = 36,
  parameter int MEMOP_WIDTH         = 12,
  parameter int TF_MEMOP_TIME_WIDTH = 12
);
  logic                           req_valid;
  logic                           req_ready;
  logic [TF_MEMOP_TIME_WIDTH-1:0] req_time;
  logic [MEMOP_WIDTH-1:0]         req_op;
  logic [ADDR_WIDTH-1:0]          req_addr;
  logic                           cmd_valid;
  logic [2:0]                     cmd_code;
  logic [1:0]                     cmd_bg;
  logic [1:0]                     cmd_bank;
  logic [15:0]                    cmd_row;
  logic [7:0]                     cmd_col;
  logic                           req_done;
  logic                           req_err;

  modport master (
    output req_valid, req_time, req_op, req_addr,
    input  req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col,
           req_done, req_err
  );

  modport slave (
    input  req_valid, req_time, req_op, req_addr,
    output req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col,
           req_done, req_err
  );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// rtl/dram_cmd_scheduler.sv - in-order open-page DDR4 command scheduler over 16 banks
module dram_cmd_scheduler #(
  parameter int ADDR_WIDTH          = 36,
  parameter int MEMOP_WIDTH         = 12,
  parameter int TF_MEMOP_TIME_WIDTH = 12,
  parameter int T_RCD               = 24,
  parameter int T_RP                = 24,
  parameter int T_RAS               = 52,
  parameter int T_RTP               = 12,
  parameter int T_CWL               = 20,
  parameter int T_BURST             = 4,
  parameter int T_WR                = 20
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [63:0]         cycle,
  dram_cmd_scheduler_if.slave bus
);
  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_PRE  = 3'd2;
  localparam logic [2:0] CMD_RD   = 3'd3;
  localparam logic [2:0] CMD_WR   = 3'd4;

  // Counters hold edges-left-minus-one so the gated command lands exactly T edges after its cause.
  localparam logic [7:0] LD_RCD = 8'(T_RCD - 1);
  localparam logic [7:0] LD_RP  = 8'(T_RP - 1);
  localparam logic [7:0] LD_RAS = 8'(T_RAS - 1);
  localparam logic [7:0] LD_RTP = 8'(T_RTP - 1);
  localparam logic [7:0] LD_WRP = 8'(T_CWL + T_BURST + T_WR - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_ACT, S_CAS} state_t;

  state_t                         state, state_nx;
  logic [2:0]                     cmd_nx;
  logic                           err_nx;
  logic [TF_MEMOP_TIME_WIDTH-1:0] r_time;
  logic [MEMOP_WIDTH-1:0]         r_op;
  logic [3:0]                     r_bidx;
  logic [15:0]                    r_row;
  logic [7:0]                     r_col;
  logic [15:0]                    bank_open;
  logic [15:0]                    open_row [16];
  logic [7:0]                     act_cnt  [16];
  logic [7:0]                     cas_cnt  [16];
  logic [7:0]                     pre_cnt  [16];
  logic                           time_ok, time_soon, op_bad, is_wr;

  logic        cmd_valid_q, req_done_q, req_err_q;
  logic [2:0]  cmd_code_q;
  logic [1:0]  cmd_bg_q, cmd_bank_q;
  logic [15:0] cmd_row_q;
  logic [7:0]  cmd_col_q;

  function automatic logic [7:0] dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  assign time_ok   = cycle >= 64'(r_time);
  // WAIT decides one edge early so the first command can issue on the req_time edge itself.
  assign time_soon = ({1'b0, cycle} + 65'd1) >= 65'(r_time);
  assign op_bad    = r_op > MEMOP_WIDTH'(2);
  assign is_wr     = r_op == MEMOP_WIDTH'(1);

  always_comb begin
    state_nx = state;
    cmd_nx   = CMD_NONE;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: if (bus.req_valid) state_nx = S_WAIT;
      S_WAIT: begin
        if (op_bad) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end else if (time_soon) begin
          if (!bank_open[r_bidx])              state_nx = S_ACT;
          else if (open_row[r_bidx] == r_row)  state_nx = S_CAS;
          else                                 state_nx = S_PRE;
        end
      end
      S_PRE: if (pre_cnt[r_bidx] == 8'd0 && time_ok) begin
        cmd_nx   = CMD_PRE;
        state_nx = S_ACT;
      end
      S_ACT: if (act_cnt[r_bidx] == 8'd0 && time_ok) begin
        cmd_nx   = CMD_ACT;
        state_nx = S_CAS;
      end
      S_CAS: if (cas_cnt[r_bidx] == 8'd0 && time_ok) begin
        cmd_nx   = is_wr ? CMD_WR : CMD_RD;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      r_time      <= '0;
      r_op        <= '0;
      r_bidx      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      bank_open   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CMD_NONE;
      cmd_bg_q    <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      req_done_q  <= 1'b0;
      req_err_q   <= 1'b0;
      for (int b = 0; b < 16; b++) begin
        open_row[b] <= '0;
        act_cnt[b]  <= '0;
        cas_cnt[b]  <= '0;
        pre_cnt[b]  <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == S_IDLE && bus.req_valid) begin
        r_time <= bus.req_time;
        r_op   <= bus.req_op;
        r_bidx <= {bus.req_addr[7:6], bus.req_addr[9:8]};
        r_col  <= bus.req_addr[17:10];
        r_row  <= bus.req_addr[33:18];
      end
      cmd_valid_q <= cmd_nx != CMD_NONE;
      cmd_code_q  <= cmd_nx;
      cmd_bg_q    <= (cmd_nx != CMD_NONE) ? r_bidx[3:2] : 2'd0;
      cmd_bank_q  <= (cmd_nx != CMD_NONE) ? r_bidx[1:0] : 2'd0;
      cmd_row_q   <= (cmd_nx == CMD_ACT) ? r_row : 16'd0;
      cmd_col_q   <= (cmd_nx == CMD_RD || cmd_nx == CMD_WR) ? r_col : 8'd0;
      req_done_q  <= cmd_nx == CMD_RD || cmd_nx == CMD_WR;
      req_err_q   <= err_nx;
      for (int b = 0; b < 16; b++) begin
        act_cnt[b] <= dec(act_cnt[b]);
        cas_cnt[b] <= dec(cas_cnt[b]);
        pre_cnt[b] <= dec(pre_cnt[b]);
      end
      case (cmd_nx)
        CMD_PRE: begin
          bank_open[r_bidx] <= 1'b0;
          act_cnt[r_bidx]   <= LD_RP;
        end
        CMD_ACT: begin
          bank_open[r_bidx] <= 1'b1;
          open_row[r_bidx]  <= r_row;
          cas_cnt[r_bidx]   <= LD_RCD;
          pre_cnt[r_bidx]   <= LD_RAS;
        end
        CMD_RD:  pre_cnt[r_bidx] <= max8(dec(pre_cnt[r_bidx]), LD_RTP);
        CMD_WR:  pre_cnt[r_bidx] <= max8(dec(pre_cnt[r_bidx]), LD_WRP);
        default: ;
      endcase
    end
  end

  assign bus.req_ready = state == S_IDLE;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_bg    = cmd_bg_q;
  assign bus.cmd_bank  = cmd_bank_q;
  assign bus.cmd_row   = cmd_row_q;
  assign bus.cmd_col   = cmd_col_q;
  assign bus.req_done  = req_done_q;
  assign bus.req_err   = req_err_q;
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb/tb_dram_cmd_scheduler.sv - directed bench for dram_cmd_scheduler command ordering and timing
module tb_dram_cmd_scheduler;
  localparam logic [63:0] NO_CMD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] cyc = 64'd0;
  int          tests = 0;
  int          fails = 0;

  logic [63:0] c_at;
  logic [2:0]  c_code;
  logic [1:0]  c_bg, c_bk;
  logic [15:0] c_row;
  logic [7:0]  c_col;
  logic        c_done;
  logic [63:0] t_acc;

  dram_cmd_scheduler_if bus ();

  dram_cmd_scheduler dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cycle   (cyc),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  // The DUT samples the pre-increment value, so an edge's cycle number is cyc-1 when read after it.
  always @(posedge clock) cyc <= cyc + 64'd1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic go_to(input logic [63:0] n);
    while (cyc < n) tick();
  endtask

  // Inputs set now are sampled at the edge numbered cyc; returns that accept edge.
  task automatic send(input logic [11:0] t, input logic [11:0] op, input logic [35:0] addr);
    t_acc            = cyc;
    bus.req_valid    = 1'b1;
    bus.req_time     = t;
    bus.req_op       = op;
    bus.req_addr     = addr;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  task automatic wait_cmd(input int budget);
    c_at = NO_CMD; c_code = 3'd0; c_bg = 2'd0; c_bk = 2'd0;
    c_row = 16'd0; c_col = 8'd0; c_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.cmd_valid) begin
        c_at   = cyc - 64'd1;
        c_code = bus.cmd_code;
        c_bg   = bus.cmd_bg;
        c_bk   = bus.cmd_bank;
        c_row  = bus.cmd_row;
        c_col  = bus.cmd_col;
        c_done = bus.req_done;
        break;
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_time  = '0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    repeat (3) tick();
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst_cmd_code", 64'(bus.cmd_code), 64'd0);
    check("rst_done_err", 64'({bus.req_done, bus.req_err}), 64'd0);
    tick();
    reset_n = 1'b1;
    go_to(64'd10);

    // closed bank read: ACT at E+2, RD at E+2+tRCD
    send(12'd0, 12'd0, 36'h0_0004_0440);
    check("t1_ready_low", 64'(bus.req_ready), 64'd0);
    wait_cmd(60);
    check("t1_act_at", c_at, 64'd12);
    check("t1_act_code", 64'(c_code), 64'd1);
    check("t1_act_bg_bk", 64'({c_bg, c_bk}), 64'h4);
    check("t1_act_row_col", 64'({c_row, c_col}), 64'h0100);
    wait_cmd(60);
    check("t1_rd_at", c_at, 64'd36);
    check("t1_rd_code", 64'(c_code), 64'd3);
    check("t1_rd_row_col", 64'({c_row, c_col}), 64'h0001);
    check("t1_rd_done", 64'(c_done), 64'd1);
    check("t1_ready_back", 64'(bus.req_ready), 64'd1);

    // row hit: RD straight away, no ACT or PRE
    send(12'd0, 12'd0, 36'h0_0004_0440);
    check("t2_accept", t_acc, 64'd37);
    wait_cmd(60);
    check("t2_rd_at", c_at, 64'd39);
    check("t2_rd_code", 64'(c_code), 64'd3);

    // row miss (instruction fetch): PRE held by tRAS, then tRP, then tRCD
    send(12'd0, 12'd2, 36'h0_0008_0440);
    wait_cmd(100);
    check("t3_pre_at", c_at, 64'd64);
    check("t3_pre_code", 64'(c_code), 64'd2);
    wait_cmd(100);
    check("t3_act_at", c_at, 64'd88);
    check("t3_act_row", 64'({c_code, c_row}), 64'h1_0002);
    wait_cmd(100);
    check("t3_rd_at", c_at, 64'd112);
    check("t3_rd_code", 64'(c_code), 64'd3);

    // write row hit, then row miss: PRE waits tCWL+tBURST+tWR after WR
    send(12'd0, 12'd1, 36'h0_0008_0440);
    wait_cmd(60);
    check("t4_wr_at", c_at, 64'd115);
    check("t4_wr_code_done", 64'({c_code, c_done}), 64'h9);
    send(12'd0, 12'd0, 36'h0_000C_0440);
    wait_cmd(100);
    check("t4_pre_at", c_at, 64'd159);
    check("t4_pre_code", 64'(c_code), 64'd2);
    wait_cmd(100);
    check("t4_act_at", c_at, 64'd183);
    check("t4_act_code", 64'(c_code), 64'd1);
    wait_cmd(100);
    check("t4_rd_at", c_at, 64'd207);
    check("t4_rd_code", 64'(c_code), 64'd3);

    // future timestamp on another bank: nothing until cycle 500
    go_to(64'd220);
    send(12'd500, 12'd0, 36'h0_0014_0180);
    wait_cmd(400);
    check("t5_act_at", c_at, 64'd500);
    check("t5_act_fields", 64'({c_code, c_bg, c_bk, c_row}), 64'h1_9_0005);
    wait_cmd(60);
    check("t5_rd_at", c_at, 64'd524);

    // illegal opcode dropped with an error pulse
    send(12'd0, 12'd7, 36'h0_0004_0440);
    tick();
    check("t6_err_pulse", 64'({bus.req_err, bus.cmd_valid}), 64'h2);
    check("t6_ready", 64'(bus.req_ready), 64'd1);
    tick();
    check("t6_err_one_clk", 64'(bus.req_err), 64'd0);
    wait_cmd(10);
    check("t6_no_cmd", c_at, NO_CMD);

    // reset two cycles after ACT aborts the request and closes the bank
    send(12'd0, 12'd0, 36'h0_001C_03C0);
    wait_cmd(10);
    check("t7_act_at", c_at, t_acc + 64'd2);
    check("t7_act_code", 64'(c_code), 64'd1);
    tick();
    tick();
    check("t7_busy", 64'(bus.req_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_async_ready", 64'(bus.req_ready), 64'd1);
    check("t7_async_quiet", 64'({bus.cmd_valid, bus.req_done, bus.req_err}), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    send(12'd0, 12'd0, 36'h0_001C_03C0);
    wait_cmd(10);
    check("t7_reopen_at", c_at, t_acc + 64'd2);
    check("t7_reopen_act", 64'({c_code, c_row}), 64'h1_0007);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
